// File: rtl/data_send_pkg.sv
// -----------------------------------------------------------------------------
// data_send_pkg
// Shared definitions for the data-send scheduling slice.
//   DEF_DATA_W : default word width, matches the datapath din width
//   state_t    : scheduler FSM encoding (S_IDLE, S_LOAD, S_SEND, S_WAIT, S_GAP)
//   idx_width  : bits needed to hold an index into n requesters (minimum 1)
// -----------------------------------------------------------------------------
package data_send_pkg;

    localparam int DEF_DATA_W = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_WAIT = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/send_scheduler_if.sv
// -----------------------------------------------------------------------------
// send_scheduler_if
// Bundles the requester side and the datapath side of the send scheduler.
//   req      : level request per requester, held until ack
//   req_data : word of requester i at [i*DATA_W +: DATA_W]
//   hold     : pauses send strobes
//   dout_vld : output-valid returned by the datapath
//   din      : word to the datapath, valid while load=1
//   load     : one-cycle load pulse
//   send     : send strobe
//   ack      : one-hot acknowledge, coincident with load
//   busy     : scheduler not idle
//   err      : sticky timeout flag
//   tx_cnt   : words completed with dout_vld, wraps at 255
// Modports: slave = the scheduler, master = requesters/datapath around it.
// -----------------------------------------------------------------------------
interface send_scheduler_if
    import data_send_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      hold;
    logic                      dout_vld;
    logic [DATA_W-1:0]         din;
    logic                      load;
    logic                      send;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic                      err;
    logic [7:0]                tx_cnt;

    modport slave (
        input  req, req_data, hold, dout_vld,
        output din, load, send, ack, busy, err, tx_cnt
    );

    modport master (
        output req, req_data, hold, dout_vld,
        input  din, load, send, ack, busy, err, tx_cnt
    );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set request bit searching upward from
// last_grant+1, wrapping modulo NUM_REQ. last_grant itself is checked last, so
// a lone requester can be granted back-to-back.
//   req        in  NUM_REQ  request vector
//   last_grant in  GW       index of the previously granted requester
//   grant      out NUM_REQ  one-hot grant (all zero when req is zero)
//   grant_idx  out GW       binary index of grant (0 when req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int GW      = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GW-1:0]      last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [GW-1:0]      grant_idx
);

    // NOTE: every signal written in this block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        logic          found;
        logic [GW-1:0] idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = GW'((int'(last_grant) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/send_scheduler.sv
// -----------------------------------------------------------------------------
// send_scheduler
// Round-robin scheduler sharing one load/send datapath among NUM_REQ
// requesters. Per word: grant in IDLE, one load pulse, SEND_CYC counted send
// strobes, wait for dout_vld (or time out after TIMEOUT cycles), one gap cycle.
//   clk  in  rising-edge clock
//   rst  in  asynchronous, active-high reset
//   bus  send_scheduler_if.slave (requests, datapath pins, status)
// Every output is a flop whose next value is decoded from the current state,
// so outputs trail the state register by one cycle: a request seen by IDLE
// shows up as load two cycles after it rises.
// -----------------------------------------------------------------------------
module send_scheduler
    import data_send_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SEND_CYC = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              rst,
    send_scheduler_if.slave   bus
);

    localparam int GW  = idx_width(NUM_REQ);
    localparam int SCW = $clog2(SEND_CYC + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    // ---------------- state and bookkeeping registers ----------------
    state_t             state_q;
    state_t             state_d;
    logic [GW-1:0]      last_grant_q;
    logic [GW-1:0]      grant_idx_q;
    logic [NUM_REQ-1:0] grant_oh_q;
    logic [DATA_W-1:0]  word_q;
    logic [SCW-1:0]     send_cnt_q;
    logic [TW-1:0]      timer_q;

    // ---------------- arbitration ----------------
    logic [NUM_REQ-1:0] arb_grant;
    logic [GW-1:0]      arb_idx;
    logic [DATA_W-1:0]  word_sel;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_arb (
        .req        (bus.req),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx)
    );

    always_comb begin
        word_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) word_sel = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // ---------------- decoded conditions ----------------
    logic send_done;
    logic wait_timeout;

    // Last counted send cycle: SEND is left on the edge that counts it.
    assign send_done    = (state_q == S_SEND) && !bus.hold
                          && (send_cnt_q == SCW'(SEND_CYC - 1));
    assign wait_timeout = (state_q == S_WAIT) && !bus.dout_vld
                          && (timer_q == TW'(TIMEOUT - 1));

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (|bus.req) state_d = S_LOAD;
            S_LOAD:  state_d = S_SEND;
            S_SEND:  if (send_done) state_d = S_WAIT;
            S_WAIT:  if (bus.dout_vld || wait_timeout) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: output logic (next output values) ----------------
    logic [DATA_W-1:0]  din_d;
    logic               load_d;
    logic               send_d;
    logic [NUM_REQ-1:0] ack_d;
    logic               busy_d;

    always_comb begin
        din_d  = bus.din;
        load_d = 1'b0;
        send_d = 1'b0;
        ack_d  = '0;
        busy_d = (state_q != S_IDLE);
        unique case (state_q)
            S_LOAD: begin
                din_d  = word_q;
                load_d = 1'b1;
                ack_d  = grant_oh_q;
            end
            S_SEND:  send_d = !bus.hold;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.din  <= '0;
            bus.load <= 1'b0;
            bus.send <= 1'b0;
            bus.ack  <= '0;
            bus.busy <= 1'b0;
        end else begin
            bus.din  <= din_d;
            bus.load <= load_d;
            bus.send <= send_d;
            bus.ack  <= ack_d;
            bus.busy <= busy_d;
        end
    end

    // ---------------- grant latch and round-robin pointer ----------------
    // The word is captured together with the grant, so a requester dropping
    // req after IDLE has decided still gets its word sent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_oh_q   <= '0;
            grant_idx_q  <= '0;
            word_q       <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
        end else begin
            if (state_q == S_IDLE && |bus.req) begin
                grant_oh_q  <= arb_grant;
                grant_idx_q <= arb_idx;
                word_q      <= word_sel;
            end
            if (state_q == S_LOAD) last_grant_q <= grant_idx_q;
        end
    end

    // ---------------- send counter ----------------
    // Only cycles that actually strobe send are counted, so hold merely
    // stretches SEND without losing or repeating a cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            send_cnt_q <= '0;
        end else if (state_q == S_LOAD) begin
            send_cnt_q <= '0;
        end else if (state_q == S_SEND && !bus.hold) begin
            send_cnt_q <= send_cnt_q + 1'b1;
        end
    end

    // ---------------- WAIT_VLD timer ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else if (state_q == S_WAIT) begin
            timer_q <= timer_q + 1'b1;
        end else begin
            timer_q <= '0;
        end
    end

    // ---------------- status: sticky error and word counter ----------------
    // dout_vld outside WAIT is ignored; tx_cnt wraps naturally at 8 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.err    <= 1'b0;
            bus.tx_cnt <= '0;
        end else begin
            if (wait_timeout) bus.err <= 1'b1;
            if (state_q == S_WAIT && bus.dout_vld) bus.tx_cnt <= bus.tx_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_send_scheduler.sv
// -----------------------------------------------------------------------------
// tb_send_scheduler
// Self-checking bench for send_scheduler (NUM_REQ=4, DATA_W=4, SEND_CYC=4,
// TIMEOUT=16). A responder plays the datapath (dout_vld after the fourth send
// strobe of a word); a monitor pops expected {ack, din} from a scoreboard on
// every load pulse and counts send strobes.
// -----------------------------------------------------------------------------
module tb_send_scheduler;

    localparam int NR = 4;
    localparam int DW = 4;

    logic clk;
    logic rst;

    send_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

    send_scheduler #(
        .NUM_REQ  (NR),
        .DATA_W   (DW),
        .SEND_CYC (4),
        .TIMEOUT  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [3:0] ack;
        logic [3:0] din;
    } exp_t;

    exp_t sb[$];

    int   sends_seen    = 0;
    int   last_send_cyc = 0;
    logic vld_en        = 1'b1;
    logic vld_poke      = 1'b0;
    int   dp_cnt        = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Datapath stand-in: one-cycle dout_vld right after the fourth send strobe.
    initial forever begin
        @(negedge clk);
        bus.dout_vld = vld_poke;
        if (rst || bus.load) begin
            dp_cnt = 0;
        end else if (bus.send) begin
            dp_cnt++;
            if (dp_cnt == 4) begin
                dp_cnt = 0;
                if (vld_en) bus.dout_vld = 1'b1;
            end
        end
    end

    // Monitor: scoreboard compare on each load, send strobe accounting.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst) begin
            if (bus.load) begin
                if (sb.size() == 0) begin
                    check("unexpected_load", 32'(bus.load), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack", 32'(bus.ack), 32'(e.ack));
                    check("din", 32'(bus.din), 32'(e.din));
                end
                sends_seen = 0;
            end else if (bus.ack != '0) begin
                check("ack_without_load", 32'(bus.ack), 32'd0);
            end
            if (bus.send) begin
                sends_seen++;
                last_send_cyc = cyc;
            end
        end
    end

    task automatic wait_load(output int c);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.load && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.load) check("load_timeout", 32'(bus.load), 32'd1);
        c = cyc;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    // Table of single-transaction vectors for round-robin corner cases.
    typedef struct packed {
        logic [3:0]  req;
        logic [15:0] data;
        logic [3:0]  ack;
        logic [3:0]  din;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int         lc;
        int         prev;
        int         t0;
        logic [7:0] exp_tx;

        // Pointer sequence starting from last_grant=0.
        vecs[0] = '{4'b0001, 16'h1234, 4'b0001, 4'h4};
        vecs[1] = '{4'b1001, 16'h8765, 4'b1000, 4'h8};
        vecs[2] = '{4'b1001, 16'hF00E, 4'b0001, 4'hE};
        vecs[3] = '{4'b0110, 16'h0A50, 4'b0010, 4'h5};
        vecs[4] = '{4'b0110, 16'h0B70, 4'b0100, 4'hB};
        vecs[5] = '{4'b1010, 16'hD0C0, 4'b1000, 4'hD};
        vecs[6] = '{4'b0100, 16'h0600, 4'b0100, 4'h6};

        exp_tx       = 8'd0;
        rst          = 1'b1;
        bus.req      = '0;
        bus.req_data = '0;
        bus.hold     = 1'b0;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("rst_load", 32'(bus.load), 32'd0);
        check("rst_send", 32'(bus.send), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_tx_cnt", 32'(bus.tx_cnt), 32'd0);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_din", 32'(bus.din), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // ---- all requesters: rotation 0,1,2,3,0 at 8-cycle spacing ----
        bus.req_data = 16'h936C;
        sb.push_back('{4'b0001, 4'hC});
        sb.push_back('{4'b0010, 4'h6});
        sb.push_back('{4'b0100, 4'h3});
        sb.push_back('{4'b1000, 4'h9});
        sb.push_back('{4'b0001, 4'hC});
        bus.req = 4'b1111;
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_load(lc);
            if (k > 0) check("rr_period", 32'(lc - prev), 32'd8);
            prev = lc;
        end
        bus.req = '0;
        wait_idle();
        exp_tx += 8'd5;
        check("rr_tx_cnt", 32'(bus.tx_cnt), 32'(exp_tx));

        // ---- single req[0]: latency, din, four sends, tx_cnt ----
        bus.req_data = 16'h0009;
        sb.push_back('{4'b0001, 4'h9});
        t0 = cyc;
        bus.req = 4'b0001;
        wait_load(lc);
        check("req_to_load_latency", 32'(lc - t0), 32'd2);
        bus.req = '0;
        wait_idle();
        exp_tx += 8'd1;
        check("single_sends", 32'(sends_seen), 32'd4);
        check("single_tx_cnt", 32'(bus.tx_cnt), 32'(exp_tx));
        check("single_busy_low", 32'(bus.busy), 32'd0);

        // ---- table-driven round-robin vectors ----
        for (int v = 0; v < 7; v++) begin
            bus.req_data = vecs[v].data;
            sb.push_back('{vecs[v].ack, vecs[v].din});
            bus.req = vecs[v].req;
            wait_load(lc);
            bus.req      = '0;
            bus.req_data = '0;
            wait_idle();
            exp_tx += 8'd1;
            check("vec_sends", 32'(sends_seen), 32'd4);
            check("vec_tx_cnt", 32'(bus.tx_cnt), 32'(exp_tx));
        end

        // ---- hold toggled 1-on/1-off through SEND ----
        bus.req_data = 16'h00F0;
        sb.push_back('{4'b0010, 4'hF});
        bus.req = 4'b0010;
        wait_load(lc);
        bus.req = '0;
        for (int i = 0; i < 8; i++) begin
            bus.hold = (i % 2 == 0);
            @(negedge clk);
        end
        bus.hold = 1'b0;
        wait_idle();
        exp_tx += 8'd1;
        check("hold_sends", 32'(sends_seen), 32'd4);
        check("hold_send_span", 32'(last_send_cyc - lc), 32'd8);
        check("hold_tx_cnt", 32'(bus.tx_cnt), 32'(exp_tx));

        // ---- missing dout_vld: timeout after 16 WAIT cycles ----
        vld_en       = 1'b0;
        bus.req_data = 16'h7000;
        sb.push_back('{4'b1000, 4'h7});
        bus.req = 4'b1000;
        wait_load(lc);
        bus.req = '0;
        repeat (4) @(negedge clk);
        check("to_sends", 32'(sends_seen), 32'd4);
        repeat (15) @(negedge clk);
        check("err_before_timeout", 32'(bus.err), 32'd0);
        @(negedge clk);
        check("err_at_timeout", 32'(bus.err), 32'd1);
        check("to_tx_cnt", 32'(bus.tx_cnt), 32'(exp_tx));
        vld_en = 1'b1;
        wait_idle();
        bus.req_data = 16'h0002;
        sb.push_back('{4'b0001, 4'h2});
        bus.req = 4'b0001;
        wait_load(lc);
        bus.req = '0;
        wait_idle();
        exp_tx += 8'd1;
        check("after_to_tx_cnt", 32'(bus.tx_cnt), 32'(exp_tx));
        check("err_sticky", 32'(bus.err), 32'd1);

        // ---- reset mid-SEND ----
        bus.req_data = 16'h00B0;
        sb.push_back('{4'b0010, 4'hB});
        bus.req = 4'b0010;
        wait_load(lc);
        bus.req = '0;
        repeat (2) @(negedge clk);
        check("pre_rst_send", 32'(bus.send), 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_send", 32'(bus.send), 32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_err", 32'(bus.err), 32'd0);
        check("async_rst_tx_cnt", 32'(bus.tx_cnt), 32'd0);
        check("async_rst_din", 32'(bus.din), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        exp_tx = 8'd0;
        repeat (5) @(negedge clk);
        bus.req_data = 16'h0D00;
        sb.push_back('{4'b0100, 4'hD});
        bus.req = 4'b0100;
        wait_load(lc);
        bus.req = '0;
        wait_idle();
        exp_tx += 8'd1;
        check("post_rst_tx_cnt", 32'(bus.tx_cnt), 32'(exp_tx));

        // ---- 255 more words: tx_cnt wraps to 0; stray vld ignored ----
        bus.req_data = 16'h0005;
        for (int k = 0; k < 255; k++) sb.push_back('{4'b0001, 4'h5});
        bus.req = 4'b0001;
        for (int k = 0; k < 255; k++) wait_load(lc);
        bus.req = '0;
        wait_idle();
        exp_tx += 8'd255;
        check("wrap_tx_cnt", 32'(bus.tx_cnt), 32'(exp_tx));
        vld_poke = 1'b1;
        repeat (2) @(negedge clk);
        vld_poke = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_vld_tx_cnt", 32'(bus.tx_cnt), 32'(exp_tx));
        check("idle_vld_busy", 32'(bus.busy), 32'd0);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
